cpu_multicycle: RTL and testbench
=================================

Name: cpu_multicycle

Overview:
- Parametrised multi-cycle successor to the team's single-cycle 8-bit CPU.
- Executes the same 12-opcode ISA, plus bne, through an explicit FETCH/DECODE/EXEC/MEM/WB state machine.
- Data width, register count and data-address width are generic.
- Instruction fetch uses the instruction memory's BUSYWAIT handshake; data access uses the data cache's READ/WRITE/BUSYWAIT handshake.
- Illegal opcodes trap into a HALT state instead of being silently ignored.

Parameters:
- DATA_W, 8, datapath, register and memory data width (>=8).
- NUM_REGS, 8, number of general registers (power of 2, 2..256); REG_AW = clog2(NUM_REGS) is a localparam.
- ADDR_W, 8, data-memory address width (<= DATA_W).
- RESET_PC, 32'h0, PC value loaded on reset.

Ports:
- CLK  in  1  system clock, rising edge.
- RESET  in  1  asynchronous, active-low reset.
- PC  out  32  address of the current instruction.
- INSTR_REQ  out  1  instruction fetch request.
- INSTRUCTION  in  32  instruction word; valid when INSTR_REQ=1 and INSTR_BUSYWAIT=0.
- INSTR_BUSYWAIT  in  1  instruction memory stall.
- READ  out  1  data-memory read request.
- WRITE  out  1  data-memory write request.
- ADDRESS  out  ADDR_W  data address, low ADDR_W bits of the ALU result.
- WRITEDATA  out  DATA_W  store data.
- READDATA  in  DATA_W  load data; valid when BUSYWAIT=0 during a READ.
- BUSYWAIT  in  1  data-memory stall.
- HALTED  out  1  core is trapped on an illegal opcode.

Behaviour:
- Instruction format: [31:24] opcode, [23:16] rd/offset, [15:8] rt, [7:0] rs/imm. Register fields use their low REG_AW bits.
- imm and offset are sign-extended to DATA_W and 32 bits respectively.
- Opcodes: loadi 00, mov 01, add 02, sub 03, and 04, or 05, j 06, beq 07, lwd 08, lwi 09, swd 0A, swi 0B, bne 0C (new). Any other opcode is illegal.
- Reset (RESET=0, asynchronous):
  - state=FETCH, PC=RESET_PC, all registers=0.
  - READ=WRITE=INSTR_REQ=HALTED=0 immediately, even mid-MEM.
  - The first INSTR_REQ rises in the first cycle after release.
- FETCH:
  - INSTR_REQ=1.
  - At the first edge with INSTR_BUSYWAIT=0: latch IR, go to DECODE. Otherwise stay in FETCH with PC held.
- DECODE:
  - Read rt and rs, latch operands A and B.
  - Illegal opcode -> HALT.
- EXEC:
  - ALU: forward, add, sub (A + ~B + 1), and, or. Width is DATA_W with wrap-around; there is no carry or overflow output.
  - Latch ALUOUT and ZERO = (ALUOUT==0).
  - j, beq taken (ZERO=1), bne taken (ZERO=0): PC = PC + 4 + (sext(offset) << 2), then FETCH.
  - beq/bne not taken: PC = PC + 4, then FETCH.
  - lwd, lwi, swd, swi -> MEM. All other opcodes -> WB.
- MEM:
  - READ=1 (loads) or WRITE=1 (stores), held until the edge where BUSYWAIT=0.
  - WRITEDATA = value of rd; ADDRESS is stable for the whole state.
  - On completion, READ/WRITE drop at that edge.
  - Loads latch READDATA and go to WB. Stores set PC+=4 and go to FETCH.
- WB:
  - Write rd with ALUOUT (or the load data).
  - PC+=4, then FETCH.
- Latency with zero-wait memories:
  - ALU ops: 4 cycles.
  - Branch/jump: 3 cycles.
  - Store: 4 cycles.
  - Load: 5 cycles.
- READ and WRITE are never high simultaneously.
- INSTR_REQ and READ/WRITE are never high simultaneously.
- PC changes only on instruction retirement.
- HALT:
  - HALTED=1 from the next cycle, absorbing until reset.
  - No requests issued; PC stays at the faulting instruction.
- PC arithmetic is 32-bit modulo; wrap-around past 32'hFFFFFFFC is legal.

Decomposition:
- Package cpu_pkg holds:
  - opcode constants;
  - ALU operation codes (FWD, ADD, SUB, AND, OR);
  - state enum (FETCH, DECODE, EXEC, MEM, WB, HALT).
- One sub-module, reg_file_p: parametrised DATA_W × NUM_REGS register file.
  - Two asynchronous read ports, one synchronous write port.
  - Asynchronous active-low clear.
- ALU and control logic remain inline.

Test Plan:
- Reset mid-load: drop RESET while READ=1 and BUSYWAIT=1 -> READ=0 with no clock edge, PC=0. After release, INSTR_REQ=1 the next cycle.
- Zero-wait program: loadi r1,5; loadi r2,3; sub r3,r1,r2; swi r3,0x10 -> mem[0x10]=2. Each ALU instruction takes 4 cycles; PC reads 0,4,8,C at retirement.
- lwi r4,0x10 with BUSYWAIT=1 for 3 cycles -> READ high 4 cycles, ADDRESS=0x10 stable, r4=2 after WB, PC unchanged until then.
- beq taken with offset 0xFE at PC=0x10 -> PC=0x0C. bne with equal operands -> PC=0x14. j 0x02 at PC=0 -> PC=0x0C.
- Opcode 0xFF at PC=0x20 -> HALTED=1, PC stays 0x20, INSTR_REQ/READ/WRITE stay 0 for 20 cycles; reset clears HALTED.
- DATA_W=16, NUM_REGS=16: loadi r15,0x80 -> r15=0xFF80. Then loadi r14,0x7F; add overflow case 0x7FFF+1 -> 0x8000.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle core: opcodes, ALU operations, FSM states.
package cpu_pkg;

   localparam logic [7:0] OP_LOADI = 8'h00;
   localparam logic [7:0] OP_MOV   = 8'h01;
   localparam logic [7:0] OP_ADD   = 8'h02;
   localparam logic [7:0] OP_SUB   = 8'h03;
   localparam logic [7:0] OP_AND   = 8'h04;
   localparam logic [7:0] OP_OR    = 8'h05;
   localparam logic [7:0] OP_J     = 8'h06;
   localparam logic [7:0] OP_BEQ   = 8'h07;
   localparam logic [7:0] OP_LWD   = 8'h08;
   localparam logic [7:0] OP_LWI   = 8'h09;
   localparam logic [7:0] OP_SWD   = 8'h0A;
   localparam logic [7:0] OP_SWI   = 8'h0B;
   localparam logic [7:0] OP_BNE   = 8'h0C;

   typedef enum logic [2:0] {
      ALU_FWD,
      ALU_ADD,
      ALU_SUB,
      ALU_AND,
      ALU_OR
   } alu_op_t;

   typedef enum logic [2:0] {
      FETCH,
      DECODE,
      EXEC,
      MEM,
      WB,
      HALT
   } state_t;

   // Opcodes are dense from 00 to 0C; anything above traps.
   function automatic logic is_legal(input logic [7:0] op);
      return op <= OP_BNE;
   endfunction

endpackage

// File: rtl/reg_file_p.sv
// Parametrised register file: two asynchronous read ports, one synchronous
// write port, asynchronous active-low clear.
module reg_file_p #(
   parameter int DATA_W   = 8,
   parameter int NUM_REGS = 8,
   localparam int REG_AW  = $clog2(NUM_REGS)
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic [REG_AW-1:0] raddr1,
   output logic [DATA_W-1:0] rdata1,
   input  logic [REG_AW-1:0] raddr2,
   output logic [DATA_W-1:0] rdata2,
   input  logic              we,
   input  logic [REG_AW-1:0] waddr,
   input  logic [DATA_W-1:0] wdata
);

   logic [DATA_W-1:0] regs [NUM_REGS];

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      end else if (we) begin
         regs[waddr] <= wdata;
      end
   end

   assign rdata1 = regs[raddr1];
   assign rdata2 = regs[raddr2];

endmodule

// File: rtl/cpu_multicycle.sv
// Multi-cycle core for the 8-bit ISA (plus bne): FETCH/DECODE/EXEC/MEM/WB with
// handshaked instruction and data memories; illegal opcodes trap into HALT.
module cpu_multicycle
   import cpu_pkg::*;
#(
   parameter int          DATA_W   = 8,
   parameter int          NUM_REGS = 8,
   parameter int          ADDR_W   = 8,
   parameter logic [31:0] RESET_PC = 32'h0
) (
   input  logic              CLK,
   input  logic              RESET,
   output logic [31:0]       PC,
   output logic              INSTR_REQ,
   input  logic [31:0]       INSTRUCTION,
   input  logic              INSTR_BUSYWAIT,
   output logic              READ,
   output logic              WRITE,
   output logic [ADDR_W-1:0] ADDRESS,
   output logic [DATA_W-1:0] WRITEDATA,
   input  logic [DATA_W-1:0] READDATA,
   input  logic              BUSYWAIT,
   output logic              HALTED
);

   localparam int REG_AW = $clog2(NUM_REGS);

   state_t            state, state_nx;
   alu_op_t           alu_op;
   logic [31:0]       ir;
   logic [7:0]        opcode;
   logic [REG_AW-1:0] rd_f, rt_f, rs_f, raddr1;
   logic [DATA_W-1:0] opa, opb, aluout, mdr, alu_res, imm_ext;
   logic [DATA_W-1:0] rdata1, rdata2, wb_data;
   logic [31:0]       pc_plus4, br_target, pc_nx;
   logic              pc_en, alu_zero, take_branch;
   logic              is_load, is_store, is_mem, is_branch, use_imm;
   logic              unused_rt_bits;

   assign opcode = ir[31:24];
   assign rd_f   = ir[16 +: REG_AW];
   assign rt_f   = ir[8 +: REG_AW];
   assign rs_f   = ir[0 +: REG_AW];
   assign unused_rt_bits = ^ir[15:8];

   assign is_load   = (opcode == OP_LWD) || (opcode == OP_LWI);
   assign is_store  = (opcode == OP_SWD) || (opcode == OP_SWI);
   assign is_mem    = is_load || is_store;
   assign is_branch = (opcode == OP_J) || (opcode == OP_BEQ) || (opcode == OP_BNE);
   assign use_imm   = (opcode == OP_LOADI) || (opcode == OP_LWI) || (opcode == OP_SWI);

   assign imm_ext   = DATA_W'($signed(ir[7:0]));
   assign pc_plus4  = PC + 32'd4;
   assign br_target = pc_plus4 + (32'($signed(ir[23:16])) << 2);

   // Stores need rd as their data, so port 1 reads rd instead of rt for them.
   assign raddr1  = is_store ? rd_f : rt_f;
   assign wb_data = is_load ? mdr : aluout;

   reg_file_p #(
      .DATA_W   (DATA_W),
      .NUM_REGS (NUM_REGS)
   ) u_rf (
      .CLK    (CLK),
      .RESET  (RESET),
      .raddr1 (raddr1),
      .rdata1 (rdata1),
      .raddr2 (rs_f),
      .rdata2 (rdata2),
      .we     (state == WB),
      .waddr  (rd_f),
      .wdata  (wb_data)
   );

   always_comb begin
      alu_op  = ALU_FWD;
      alu_res = opb;
      case (opcode)
         OP_ADD:                 alu_op = ALU_ADD;
         OP_SUB, OP_BEQ, OP_BNE: alu_op = ALU_SUB;
         OP_AND:                 alu_op = ALU_AND;
         OP_OR:                  alu_op = ALU_OR;
         default:                alu_op = ALU_FWD;
      endcase
      case (alu_op)
         ALU_ADD: alu_res = opa + opb;
         ALU_SUB: alu_res = opa + ~opb + DATA_W'(1);
         ALU_AND: alu_res = opa & opb;
         ALU_OR:  alu_res = opa | opb;
         default: alu_res = opb;
      endcase
   end

   assign alu_zero    = (alu_res == '0);
   assign take_branch = (opcode == OP_J) ||
                        ((opcode == OP_BEQ) && alu_zero) ||
                        ((opcode == OP_BNE) && !alu_zero);

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) state <= FETCH;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx  = state;
      pc_en     = 1'b0;
      pc_nx     = pc_plus4;
      INSTR_REQ = 1'b0;
      READ      = 1'b0;
      WRITE     = 1'b0;
      HALTED    = 1'b0;
      case (state)
         FETCH: begin
            // Gated by RESET so the request is low throughout reset.
            INSTR_REQ = RESET;
            if (!INSTR_BUSYWAIT) state_nx = DECODE;
         end
         DECODE: state_nx = is_legal(opcode) ? EXEC : HALT;
         EXEC: begin
            if (is_branch) begin
               state_nx = FETCH;
               pc_en    = 1'b1;
               if (take_branch) pc_nx = br_target;
            end else if (is_mem) begin
               state_nx = MEM;
            end else begin
               state_nx = WB;
            end
         end
         MEM: begin
            READ  = is_load;
            WRITE = is_store;
            if (!BUSYWAIT) begin
               if (is_load) begin
                  state_nx = WB;
               end else begin
                  state_nx = FETCH;
                  pc_en    = 1'b1;
               end
            end
         end
         WB: begin
            state_nx = FETCH;
            pc_en    = 1'b1;
         end
         HALT:    HALTED   = 1'b1;
         default: state_nx = FETCH;
      endcase
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         PC     <= RESET_PC;
         ir     <= '0;
         opa    <= '0;
         opb    <= '0;
         aluout <= '0;
         mdr    <= '0;
      end else begin
         if (state == FETCH && !INSTR_BUSYWAIT) ir <= INSTRUCTION;
         if (state == DECODE) begin
            opa <= rdata1;
            opb <= use_imm ? imm_ext : rdata2;
         end
         if (state == EXEC) aluout <= alu_res;
         if (state == MEM && !BUSYWAIT && is_load) mdr <= READDATA;
         if (pc_en) PC <= pc_nx;
      end
   end

   assign ADDRESS   = aluout[ADDR_W-1:0];
   assign WRITEDATA = opa;

endmodule

// File: tb/tb_cpu_multicycle.sv
// Scoreboard bench for cpu_multicycle: fetch PCs/latencies, reads and writes
// are predicted per program and matched against DUT bus activity.
module tb_cpu_multicycle;

   logic        CLK = 1'b0;
   logic        RESET;
   logic [31:0] PC, INSTRUCTION;
   logic        INSTR_REQ, INSTR_BUSYWAIT;
   logic        READ, WRITE, BUSYWAIT, HALTED;
   logic [7:0]  ADDRESS, WRITEDATA, READDATA;

   logic        RESET16;
   logic [31:0] pc16, instr16;
   logic        ireq16, rd16, wr16, halted16;
   logic [7:0]  addr16;
   logic [15:0] wdata16;

   always #5 CLK = ~CLK;

   cpu_multicycle dut (
      .CLK(CLK), .RESET(RESET), .PC(PC), .INSTR_REQ(INSTR_REQ),
      .INSTRUCTION(INSTRUCTION), .INSTR_BUSYWAIT(INSTR_BUSYWAIT),
      .READ(READ), .WRITE(WRITE), .ADDRESS(ADDRESS), .WRITEDATA(WRITEDATA),
      .READDATA(READDATA), .BUSYWAIT(BUSYWAIT), .HALTED(HALTED)
   );

   cpu_multicycle #(.DATA_W(16), .NUM_REGS(16)) dut16 (
      .CLK(CLK), .RESET(RESET16), .PC(pc16), .INSTR_REQ(ireq16),
      .INSTRUCTION(instr16), .INSTR_BUSYWAIT(1'b0),
      .READ(rd16), .WRITE(wr16), .ADDRESS(addr16), .WRITEDATA(wdata16),
      .READDATA(16'h7FFF), .BUSYWAIT(1'b0), .HALTED(halted16)
   );

   typedef struct { logic [31:0] pc; int gap; } fetch_t;
   typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;
   typedef struct { logic [31:0] addr; int cycles; } rd_t;

   fetch_t fq[$];
   wr_t    wq[$];
   wr_t    wq16[$];
   rd_t    rq[$];

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Memories: instruction and read stalls programmable, writes zero-wait.
   logic [31:0] imem [64];
   logic [31:0] imem16 [16];
   logic [7:0]  dmem [256];
   int iwait = 0, rwait = 0, icnt = 0, rcnt = 0;

   assign INSTRUCTION = imem[PC[7:2]];
   assign instr16     = imem16[pc16[5:2]];

   always @(negedge CLK) begin
      if (INSTR_REQ && icnt < iwait) begin
         INSTR_BUSYWAIT = 1'b1;
         icnt++;
      end else begin
         INSTR_BUSYWAIT = 1'b0;
         if (!INSTR_REQ) icnt = 0;
      end
      if (READ && rcnt < rwait) begin
         BUSYWAIT = 1'b1;
         rcnt++;
      end else begin
         BUSYWAIT = 1'b0;
         if (!READ) rcnt = 0;
      end
      READDATA = dmem[ADDRESS];
   end

   always @(posedge CLK) if (WRITE && !BUSYWAIT) dmem[ADDRESS] <= WRITEDATA;

   int cyc = 0, last_acc = 0, rd_run = 0;
   always @(posedge CLK) cyc++;

   always @(negedge CLK) begin : monitor
      fetch_t f;
      wr_t    w;
      rd_t    r;
      #1;
      if (!RESET) begin
         rd_run = 0;
      end else begin
         if (INSTR_REQ && (READ || WRITE)) check("req_exclusive", 32'd1, 32'd0);
         if (READ && WRITE) check("rw_exclusive", 32'd1, 32'd0);
         if (INSTR_REQ && !INSTR_BUSYWAIT) begin
            if (fq.size() == 0) check("fetch_unexpected", PC, 32'hDEAD_DEAD);
            else begin
               f = fq.pop_front();
               check("fetch_pc", PC, f.pc);
               if (f.gap > 0) check("fetch_gap", 32'(cyc - last_acc), 32'(f.gap));
            end
            last_acc = cyc;
         end
         if (READ) begin
            if (rq.size() == 0) check("read_unexpected", 32'(ADDRESS), 32'hDEAD_DEAD);
            else begin
               check("read_addr", 32'(ADDRESS), rq[0].addr);
               rd_run++;
               if (!BUSYWAIT) begin
                  r = rq.pop_front();
                  check("read_len", 32'(rd_run), 32'(r.cycles));
                  rd_run = 0;
               end
            end
         end
         if (WRITE && !BUSYWAIT) begin
            if (wq.size() == 0) check("write_unexpected", 32'(ADDRESS), 32'hDEAD_DEAD);
            else begin
               w = wq.pop_front();
               check("write_addr", 32'(ADDRESS), w.addr);
               check("write_data", 32'(WRITEDATA), w.data);
            end
         end
      end
      if (RESET16 && wr16) begin
         if (wq16.size() == 0) check("w16_unexpected", 32'(addr16), 32'hDEAD_DEAD);
         else begin
            w = wq16.pop_front();
            check("w16_addr", 32'(addr16), w.addr);
            check("w16_data", 32'(wdata16), w.data);
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(negedge CLK);
      #2;
   endtask

   task automatic release_reset();
      @(posedge CLK);
      #2;
      RESET = 1'b1;
      #1;
      check("req_after_release", 32'(INSTR_REQ), 32'd1);
      check("pc_after_release", PC, 32'h0);
   endtask

   task automatic enter_reset(input string tag);
      RESET = 1'b0;
      #1;
      check({tag, "_halted_clr"}, 32'(HALTED), 32'd0);
      check({tag, "_req_clr"}, {29'd0, INSTR_REQ, READ, WRITE}, 32'd0);
      check({tag, "_pc_rst"}, PC, 32'h0);
   endtask

   task automatic halt_and_hold(input string tag, input logic [31:0] pc_exp);
      bit ok = 1'b0;
      for (int i = 0; i < 300 && !ok; i++) begin
         step(1);
         ok = HALTED;
      end
      check({tag, "_halt_reached"}, 32'(ok), 32'd1);
      for (int i = 0; i < 20; i++) begin
         check({tag, "_halted"}, 32'(HALTED), 32'd1);
         check({tag, "_halt_pc"}, PC, pc_exp);
         check({tag, "_halt_quiet"}, {29'd0, INSTR_REQ, READ, WRITE}, 32'd0);
         step(1);
      end
   endtask

   task automatic check_drained(input string tag);
      check({tag, "_fetch_left"}, 32'(fq.size()), 32'd0);
      check({tag, "_write_left"}, 32'(wq.size()), 32'd0);
      check({tag, "_read_left"}, 32'(rq.size()), 32'd0);
   endtask

   task automatic clear_imem();
      for (int i = 0; i < 64; i++) imem[i] = 32'hFFFF_FFFF;
   endtask

   function automatic fetch_t fe(input logic [31:0] pc, input int gap);
      fetch_t f;
      f.pc  = pc;
      f.gap = gap;
      return f;
   endfunction

   function automatic wr_t we(input logic [31:0] a, input logic [31:0] d);
      wr_t w;
      w.addr = a;
      w.data = d;
      return w;
   endfunction

   function automatic rd_t re(input logic [31:0] a, input int c);
      rd_t r;
      r.addr   = a;
      r.cycles = c;
      return r;
   endfunction

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin : stimulus
      bit ok;
      RESET = 1'b0;
      RESET16 = 1'b0;
      INSTR_BUSYWAIT = 1'b0;
      BUSYWAIT = 1'b0;
      READDATA = '0;
      for (int i = 0; i < 256; i++) dmem[i] = '0;
      for (int i = 0; i < 16; i++) imem16[i] = 32'hFFFF_FFFF;

      // Reset in the middle of a stalled load.
      clear_imem();
      imem[0] = 32'h09_01_00_05;             // lwi r1,0x05
      rwait = 1000;
      fq.push_back(fe(32'h0, 0));
      rq.push_back(re(32'h05, 0));
      step(2);
      release_reset();
      ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
         step(1);
         ok = READ;
      end
      check("a_read_seen", 32'(ok), 32'd1);
      step(2);
      check("a_read_held", {30'd0, READ, BUSYWAIT}, 32'd3);
      enter_reset("a");
      fq.delete();
      rq.delete();
      rwait = 3;

      // ALU chain, store, stalled load, store, halt at 0x18.
      clear_imem();
      imem[0] = 32'h00_01_00_05;             // loadi r1,5
      imem[1] = 32'h00_02_00_03;             // loadi r2,3
      imem[2] = 32'h03_03_01_02;             // sub r3,r1,r2
      imem[3] = 32'h0B_03_00_10;             // swi r3,0x10
      imem[4] = 32'h09_04_00_10;             // lwi r4,0x10
      imem[5] = 32'h0B_04_00_11;             // swi r4,0x11
      fq.push_back(fe(32'h00, 0));
      fq.push_back(fe(32'h04, 4));
      fq.push_back(fe(32'h08, 4));
      fq.push_back(fe(32'h0C, 4));
      fq.push_back(fe(32'h10, 4));
      fq.push_back(fe(32'h14, 8));
      fq.push_back(fe(32'h18, 4));
      wq.push_back(we(32'h10, 32'h02));
      wq.push_back(we(32'h11, 32'h02));
      rq.push_back(re(32'h10, 4));
      step(2);
      release_reset();
      halt_and_hold("b", 32'h18);
      check_drained("b");
      enter_reset("b");

      // Jumps and branches with a one-cycle fetch stall on every fetch.
      iwait = 1;
      clear_imem();
      imem[0] = 32'h00_01_00_01;             // loadi r1,1
      imem[1] = 32'h06_02_00_00;             // j +2
      imem[3] = 32'h00_02_00_09;             // loadi r2,9
      imem[4] = 32'h07_FE_02_03;             // beq r2,r3,-2
      imem[5] = 32'h0C_05_01_01;             // bne r1,r1,+5
      imem[6] = 32'h0B_02_00_31;             // swi r2,0x31
      imem[7] = 32'h0C_01_01_02;             // bne r1,r2,+1
      fq.push_back(fe(32'h00, 0));
      fq.push_back(fe(32'h04, 5));
      fq.push_back(fe(32'h10, 4));
      fq.push_back(fe(32'h0C, 4));
      fq.push_back(fe(32'h10, 5));
      fq.push_back(fe(32'h14, 4));
      fq.push_back(fe(32'h18, 4));
      fq.push_back(fe(32'h1C, 5));
      fq.push_back(fe(32'h24, 4));
      wq.push_back(we(32'h31, 32'h09));
      step(2);
      release_reset();
      halt_and_hold("c", 32'h24);
      check_drained("c");
      enter_reset("c");
      iwait = 0;

      // 16-bit core, 16 registers: sign extension and wrap-around add.
      imem16[0] = 32'h00_0F_00_80;           // loadi r15,0x80
      imem16[1] = 32'h0B_0F_00_10;           // swi r15,0x10
      imem16[2] = 32'h00_0E_00_7F;           // loadi r14,0x7F
      imem16[3] = 32'h0B_0E_00_11;           // swi r14,0x11
      imem16[4] = 32'h09_0D_00_20;           // lwi r13,0x20 (reads 0x7FFF)
      imem16[5] = 32'h00_0C_00_01;           // loadi r12,1
      imem16[6] = 32'h02_0B_0D_0C;           // add r11,r13,r12
      imem16[7] = 32'h0B_0B_00_12;           // swi r11,0x12
      wq16.push_back(we(32'h10, 32'hFF80));
      wq16.push_back(we(32'h11, 32'h007F));
      wq16.push_back(we(32'h12, 32'h8000));
      @(posedge CLK);
      #2;
      RESET16 = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 300 && !ok; i++) begin
         step(1);
         ok = halted16;
      end
      check("d_halt_reached", 32'(ok), 32'd1);
      check("d_halt_pc", pc16, 32'h20);
      check("d_write_left", 32'(wq16.size()), 32'd0);
      RESET16 = 1'b0;
      #1;
      check("d_halted_clr", 32'(halted16), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
